phase_checker: RTL and testbench
================================

# phase_checker

Receive-side partner of the CPU phase sequencer: samples the five one-hot phase strobes (fetch, decode, execute, memory, writeback), decodes them back to a phase index, and checks the 6-cycle frame protocol (F, D, E, M, W, idle). It also counts retired instructions and flags protocol faults with a sticky error and cause code. It sits beside the sequencer in the control path and feeds debug/status logic.

## Interface
- CNT_W, 16, width of retire counter (wraps modulo 2^CNT_W)
- clk  in  1  rising-edge clock, same domain as sequencer
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values
- fetch, decode, execute, memory, writeback  in  1 each  phase strobes from sequencer, treated as vector {writeback,memory,execute,decode,fetch}
- err_clr  in  1  synchronous clear of err/err_code
- phase  out  3  registered decoded index: 0=F 1=D 2=E 3=M 4=W 5=idle (no strobe)
- phase_valid  out  1  registered; 1 when exactly one or zero strobes sampled (legal encoding)
- locked  out  1  checker synchronised to frame
- instr_done  out  1  one-cycle pulse per correctly sequenced writeback
- retire_count  out  CNT_W  count of instr_done pulses
- err  out  1  sticky fault flag
- err_code  out  2  00 none, 01 multi-hot, 10 out-of-order, 11 missing strobe

## Operation
- States: SEARCH (reset state), LOCKED, FAULT. Expected-phase register exp (0..5).
- All inputs sampled at each posedge; all outputs registered.
- Multi-hot (popcount > 1) in any state: err_code=01, err=1, go FAULT, phase holds previous value, phase_valid=0.
- SEARCH: ignore everything except a lone fetch; lone fetch → LOCKED, exp=1. Non-fetch single strobes are not errors.
- LOCKED: exp 0..4 requires lone strobe of index exp; exp 5 requires zero strobes. Match → exp = (exp==5) ? 0 : exp+1. Match at exp=4 → instr_done=1, retire_count+1 (wraps from all-ones to 0).
- LOCKED mismatch: zero strobes at exp 0..4 → code 11; wrong lone strobe, or any strobe at exp 5 → code 10. Set err, go FAULT, locked=0.
- FAULT: locked=0, no counting. Exit is governed by Configuration.
- err_clr: clears err and err_code to 0; a new error detected the same cycle wins (err=1, new code).
- Reset mid-frame: immediate return to SEARCH, counter and err cleared.

## Timing
- Reset values: phase=5, phase_valid=0, locked=0, instr_done=0, retire_count=0, err=0, err_code=00.
- Latency 1 cycle: strobe sampled at edge N is reflected on phase/phase_valid/instr_done/err after edge N.
- locked rises after the edge that samples the lock-acquiring fetch; falls after the edge that samples the fault.
- retire_count increments on the same edge instr_done goes high.
- Steady-state legal stream: instr_done pulses once every 6 cycles.

## Configuration
- PHASE_CHK_RESYNC_EN defined: in FAULT, a lone fetch → LOCKED, exp=1 (relock). err/err_code stay sticky until err_clr.
- Undefined: FAULT is terminal until reset; strobes only update phase/phase_valid.

## Structure
- Package cpu_phase_pkg: phase index constants PH_FETCH..PH_WB=0..4, PH_IDLE=5, state enum {SEARCH, LOCKED, FAULT}, err_code constants ERR_NONE/ERR_MULTI/ERR_ORDER/ERR_MISS.
- Sub-module phase_encoder (combinational): 5-bit one-hot → 3-bit index, none, multi-hot flags. Top holds FSM, exp, counter, error regs.

## Test plan
- Reset, then 3 legal frames from a fetch → locked=1 one cycle after first fetch, 3 instr_done pulses 6 cycles apart, retire_count=3, err=0.
- Legal frame with execute dropped (all-zero at exp=2) → err=1, err_code=11, locked=0 next cycle, retire_count frozen.
- fetch and decode high together while LOCKED → err_code=01, phase_valid=0, phase unchanged.
- decode sampled during idle slot (exp=5) → err_code=10; with PHASE_CHK_RESYNC_EN the next lone fetch relocks and counting resumes; without it locked stays 0.
- err_clr asserted alone → err=0, err_code=00; err_clr coincident with a missing strobe → err=1, err_code=11.
- CNT_W=4, 16 legal frames → retire_count wraps 15→0; reset asserted mid-frame → all outputs at reset values immediately.

Source files
------------

// File: rtl/cpu_phase_pkg.sv
// -----------------------------------------------------------------------------
// cpu_phase_pkg
//   Shared definitions for the receive-side phase checker:
//     - phase index constants (PH_FETCH..PH_WB = 0..4, PH_IDLE = 5)
//     - checker FSM state enum (SEARCH, LOCKED, FAULT)
//     - error cause codes (ERR_NONE, ERR_MULTI, ERR_ORDER, ERR_MISS)
//     - next_exp(): advance the expected-phase index around the 6-slot frame
// -----------------------------------------------------------------------------
package cpu_phase_pkg;

  localparam logic [2:0] PH_FETCH  = 3'd0;
  localparam logic [2:0] PH_DECODE = 3'd1;
  localparam logic [2:0] PH_EXEC   = 3'd2;
  localparam logic [2:0] PH_MEM    = 3'd3;
  localparam logic [2:0] PH_WB     = 3'd4;
  localparam logic [2:0] PH_IDLE   = 3'd5;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MULTI = 2'b01;
  localparam logic [1:0] ERR_ORDER = 2'b10;
  localparam logic [1:0] ERR_MISS  = 2'b11;

  // The frame is F, D, E, M, W, idle; after the idle slot it wraps to fetch.
  function automatic logic [2:0] next_exp(input logic [2:0] cur);
    logic [2:0] nxt;
    if (cur >= PH_IDLE) begin
      nxt = PH_FETCH;
    end else begin
      nxt = cur + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/phase_encoder.sv
// -----------------------------------------------------------------------------
// phase_encoder
//   Combinational decode of the five phase strobes into a phase index.
//   Ports:
//     strobes_i [4:0] : {writeback, memory, execute, decode, fetch}
//     idx_o     [2:0] : index of the lowest set strobe, PH_IDLE when none set
//     none_o          : no strobe set
//     multi_o         : more than one strobe set (illegal encoding)
// -----------------------------------------------------------------------------
module phase_encoder
  import cpu_phase_pkg::*;
(
  input  logic [4:0] strobes_i,
  output logic [2:0] idx_o,
  output logic       none_o,
  output logic       multi_o
);

  always_comb begin
    idx_o = PH_IDLE;
    // Descending scan so the lowest set bit wins; idx_o is only meaningful
    // to the caller when multi_o is low.
    for (int i = 4; i >= 0; i--) begin
      if (strobes_i[i]) begin
        idx_o = 3'(i);
      end
    end
  end

  assign none_o  = (strobes_i == 5'b00000);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = ((strobes_i & (strobes_i - 5'd1)) != 5'b00000);

endmodule

// File: rtl/phase_checker.sv
// -----------------------------------------------------------------------------
// phase_checker
//   Receive-side partner of the CPU phase sequencer. Decodes the five one-hot
//   phase strobes, tracks the 6-cycle frame (F, D, E, M, W, idle), counts
//   retired instructions and flags protocol faults with a sticky error.
//
//   Build option: define PHASE_CHK_RESYNC_EN to let a lone fetch relock the
//   checker out of FAULT. Without it, FAULT is left only through reset.
//
//   Ports:
//     clk            : rising-edge clock
//     reset          : asynchronous active-high reset
//     fetch..writeback : phase strobes, vector {writeback,memory,execute,decode,fetch}
//     err_clr        : synchronous clear of err/err_code (a new fault the same
//                      cycle takes priority)
//     phase [2:0]    : registered decoded index, 5 = idle
//     phase_valid    : registered, 1 when zero or one strobe was sampled
//     locked         : checker synchronised to the frame
//     instr_done     : one-cycle pulse per correctly sequenced writeback
//     retire_count   : count of instr_done pulses, wraps modulo 2^CNT_W
//     err, err_code  : sticky fault flag and cause
//     state_dbg      : current checker state (SEARCH/LOCKED/FAULT) for debug
//
//   Output timing: every output is registered. A strobe pattern sampled on
//   edge N is reflected on phase/phase_valid/locked/instr_done/retire_count/
//   err/err_code right after edge N. phase_valid qualifies phase each cycle;
//   there is no back-pressure, the checker observes the strobes every cycle.
// -----------------------------------------------------------------------------
module phase_checker
  import cpu_phase_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch,
  input  logic             decode,
  input  logic             execute,
  input  logic             memory,
  input  logic             writeback,
  input  logic             err_clr,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             instr_done,
  output logic [CNT_W-1:0] retire_count,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [1:0]       state_dbg
);

  logic [4:0] strobes;
  logic [2:0] enc_idx;
  logic       enc_none;
  logic       enc_multi;

  assign strobes = {writeback, memory, execute, decode, fetch};

  phase_encoder u_enc (
    .strobes_i (strobes),
    .idx_o     (enc_idx),
    .none_o    (enc_none),
    .multi_o   (enc_multi)
  );

  state_e           state_q;
  logic [2:0]       exp_q;
  logic [2:0]       phase_q;
  logic             phase_valid_q;
  logic             locked_q;
  logic             instr_done_q;
  logic [CNT_W-1:0] retire_q;
  logic             err_q;
  logic [1:0]       err_code_q;

  logic [2:0]       exp_d;
  logic [CNT_W-1:0] retire_d;
  logic             lone_fetch;
  logic             exp_match;

  assign exp_d      = next_exp(exp_q);
  assign retire_d   = retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign lone_fetch = !enc_multi && !enc_none && (enc_idx == PH_FETCH);

  // The idle slot expects silence; every other slot expects exactly its strobe.
  assign exp_match  = (exp_q == PH_IDLE) ? enc_none
                                         : (!enc_none && (enc_idx == exp_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      exp_q         <= PH_FETCH;
      phase_q       <= PH_IDLE;
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      instr_done_q  <= 1'b0;
      retire_q      <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      instr_done_q <= 1'b0;

      // Clear first; any fault detected below overrides it in the same cycle.
      if (err_clr) begin
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end

      if (enc_multi) begin
        // Illegal encoding: phase keeps its last legal value.
        phase_valid_q <= 1'b0;
        err_q         <= 1'b1;
        err_code_q    <= ERR_MULTI;
        state_q       <= FAULT;
        locked_q      <= 1'b0;
      end else begin
        phase_q       <= enc_idx;
        phase_valid_q <= 1'b1;

        case (state_q)
          SEARCH: begin
            // Only a lone fetch marks a frame start; anything else is ignored.
            if (lone_fetch) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              exp_q    <= PH_DECODE;
            end
          end

          LOCKED: begin
            if (exp_match) begin
              exp_q <= exp_d;
              if (exp_q == PH_WB) begin
                instr_done_q <= 1'b1;
                retire_q     <= retire_d;
              end
            end else begin
              // Silence where a strobe was due is a missing strobe; any other
              // mismatch (wrong strobe, or a strobe in the idle slot) is order.
              err_q      <= 1'b1;
              err_code_q <= enc_none ? ERR_MISS : ERR_ORDER;
              state_q    <= FAULT;
              locked_q   <= 1'b0;
            end
          end

          FAULT: begin
`ifdef PHASE_CHK_RESYNC_EN
            // Relock on the next frame start; err/err_code remain sticky.
            if (lone_fetch) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              exp_q    <= PH_DECODE;
            end
`else
            // Terminal until reset; only phase/phase_valid keep tracking.
            state_q <= FAULT;
`endif
          end

          default: begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            exp_q    <= PH_FETCH;
          end
        endcase
      end
    end
  end

  assign phase        = phase_q;
  assign phase_valid  = phase_valid_q;
  assign locked       = locked_q;
  assign instr_done   = instr_done_q;
  assign retire_count = retire_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_phase_checker.sv
// -----------------------------------------------------------------------------
// tb_phase_checker
//   Directed stimulus for phase_checker (CNT_W = 4 so the counter wrap is
//   reachable). Each driven cycle pushes its hand-computed expected outputs
//   into exp_q; the monitor pops one entry after each clock edge and compares.
//   Expected packing: {phase[2:0], phase_valid, locked, instr_done,
//                      retire_count[3:0], err, err_code[1:0]}
// -----------------------------------------------------------------------------
module tb_phase_checker;

  localparam int CNT_W = 4;
  localparam int W     = 13;

  localparam logic [4:0] S_N = 5'b00000;
  localparam logic [4:0] S_F = 5'b00001;
  localparam logic [4:0] S_D = 5'b00010;
  localparam logic [4:0] S_E = 5'b00100;
  localparam logic [4:0] S_M = 5'b01000;
  localparam logic [4:0] S_W = 5'b10000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]       strb    = 5'b00000;
  logic             err_clr = 1'b0;
  logic             fetch, decode, execute, memory, writeback;
  logic [2:0]       phase;
  logic             phase_valid, locked, instr_done, err;
  logic [CNT_W-1:0] retire_count;
  logic [1:0]       err_code;
  logic [1:0]       state_dbg;

  assign {writeback, memory, execute, decode, fetch} = strb;

  phase_checker #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch        (fetch),
    .decode       (decode),
    .execute      (execute),
    .memory       (memory),
    .writeback    (writeback),
    .err_clr      (err_clr),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .locked       (locked),
    .instr_done   (instr_done),
    .retire_count (retire_count),
    .err          (err),
    .err_code     (err_code),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_got;
  string        mon_name;

  function automatic logic [W-1:0] pk(input logic [2:0] ph, input logic pv,
                                      input logic lk, input logic dn,
                                      input logic [3:0] cnt, input logic er,
                                      input logic [1:0] cd);
    return {ph, pv, lk, dn, cnt, er, cd};
  endfunction

  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_got  = {phase, phase_valid, locked, instr_done, retire_count, err, err_code};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s got ph=%0d pv=%0b lk=%0b dn=%0b cnt=%0d err=%0b code=%0d expected ph=%0d pv=%0b lk=%0b dn=%0b cnt=%0d err=%0b code=%0d",
                 mon_name, mon_got[12:10], mon_got[9], mon_got[8], mon_got[7], mon_got[6:3], mon_got[2], mon_got[1:0],
                 mon_exp[12:10], mon_exp[9], mon_exp[8], mon_exp[7], mon_exp[6:3], mon_exp[2], mon_exp[1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic step(input string nm, input logic [4:0] s, input logic clr,
                      input logic [W-1:0] e);
    @(negedge clk);
    strb    = s;
    err_clr = clr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Asserts reset between edges and checks that outputs clear immediately.
  task automatic reset_pulse(input string nm);
    @(negedge clk);
    #2;
    reset   = 1'b1;
    strb    = S_N;
    err_clr = 1'b0;
    #1;
    chk({nm, "_phase"}, 32'(phase), 32'd5);
    chk({nm, "_pv"},    32'(phase_valid), 32'd0);
    chk({nm, "_lk"},    32'(locked), 32'd0);
    chk({nm, "_dn"},    32'(instr_done), 32'd0);
    chk({nm, "_cnt"},   32'(retire_count), 32'd0);
    chk({nm, "_err"},   32'(err), 32'd0);
    chk({nm, "_code"},  32'(err_code), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One legal frame while locked (or locking), counter starts at c0.
  task automatic legal_frame(input string nm, input logic [3:0] c0,
                             input logic er, input logic [1:0] cd);
    logic [3:0] c1;
    c1 = c0 + 4'd1;
    step({nm, "_F"}, S_F, 1'b0, pk(3'd0, 1'b1, 1'b1, 1'b0, c0, er, cd));
    step({nm, "_D"}, S_D, 1'b0, pk(3'd1, 1'b1, 1'b1, 1'b0, c0, er, cd));
    step({nm, "_E"}, S_E, 1'b0, pk(3'd2, 1'b1, 1'b1, 1'b0, c0, er, cd));
    step({nm, "_M"}, S_M, 1'b0, pk(3'd3, 1'b1, 1'b1, 1'b0, c0, er, cd));
    step({nm, "_W"}, S_W, 1'b0, pk(3'd4, 1'b1, 1'b1, 1'b1, c1, er, cd));
    step({nm, "_I"}, S_N, 1'b0, pk(3'd5, 1'b1, 1'b1, 1'b0, c1, er, cd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] c;

    reset_pulse("rst0");

    // Search ignores silence and non-fetch strobes.
    step("idle_search", S_N, 1'b0, pk(3'd5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0));
    step("dec_search",  S_D, 1'b0, pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0));
    legal_frame("frame1", 4'd0, 1'b0, 2'd0);
    legal_frame("frame2", 4'd1, 1'b0, 2'd0);
    legal_frame("frame3", 4'd2, 1'b0, 2'd0);

    // Execute dropped: missing strobe, counter frozen afterwards.
    step("miss_F",   S_F, 1'b0, pk(3'd0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 2'd0));
    step("miss_D",   S_D, 1'b0, pk(3'd1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 2'd0));
    step("miss_exe", S_N, 1'b0, pk(3'd5, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 2'd3));
    step("miss_M",   S_M, 1'b0, pk(3'd3, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 2'd3));
    step("miss_W",   S_W, 1'b0, pk(3'd4, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 2'd3));
    step("miss_I",   S_N, 1'b0, pk(3'd5, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 2'd3));

    // err_clr on its own.
    step("clr_alone", S_N, 1'b1, pk(3'd5, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 2'd0));
    step("clr_after", S_N, 1'b0, pk(3'd5, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 2'd0));

    // Multi-hot while locked: phase holds, phase_valid drops.
    reset_pulse("rst1");
    step("mh_F",      S_F,     1'b0, pk(3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
    step("mh_D",      S_D,     1'b0, pk(3'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
    step("multi_hot", 5'b00011, 1'b0, pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 2'd1));
    step("mh_after",  S_N,     1'b0, pk(3'd5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'd1));

    // err_clr coincident with a missing strobe: the new fault wins.
    reset_pulse("rst2");
    step("cm_F",          S_F, 1'b0, pk(3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
    step("clr_with_miss", S_N, 1'b1, pk(3'd5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'd3));

    // Decode in the idle slot: out-of-order.
    reset_pulse("rst3");
    step("oo_F", S_F, 1'b0, pk(3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
    step("oo_D", S_D, 1'b0, pk(3'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
    step("oo_E", S_E, 1'b0, pk(3'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
    step("oo_M", S_M, 1'b0, pk(3'd3, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
    step("oo_W", S_W, 1'b0, pk(3'd4, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 2'd0));
    step("dec_in_idle", S_D, 1'b0, pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 2'd2));
`ifdef PHASE_CHK_RESYNC_EN
    step("relock_F", S_F, 1'b0, pk(3'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 2'd2));
    step("relock_D", S_D, 1'b0, pk(3'd1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 2'd2));
    step("relock_E", S_E, 1'b0, pk(3'd2, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 2'd2));
    step("relock_M", S_M, 1'b0, pk(3'd3, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 2'd2));
    step("relock_W", S_W, 1'b0, pk(3'd4, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 2'd2));
    step("relock_I", S_N, 1'b0, pk(3'd5, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 2'd2));
    step("clr_locked",     S_F, 1'b1, pk(3'd0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 2'd0));
    step("clr_locked_D",   S_D, 1'b0, pk(3'd1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 2'd0));
    step("clr_with_miss2", S_N, 1'b1, pk(3'd5, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 2'd3));
`else
    step("no_relock_F", S_F, 1'b0, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 2'd2));
    step("no_relock_D", S_D, 1'b0, pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 2'd2));
    step("no_relock_E", S_E, 1'b0, pk(3'd2, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 2'd2));
    step("no_relock_M", S_M, 1'b0, pk(3'd3, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 2'd2));
    step("no_relock_W", S_W, 1'b0, pk(3'd4, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 2'd2));
    step("no_relock_I", S_N, 1'b0, pk(3'd5, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 2'd2));
`endif

    // 16 legal frames: the 4-bit counter wraps 15 -> 0 on the last writeback.
    reset_pulse("rst4");
    for (int i = 0; i < 16; i++) begin
      c = 4'(i);
      legal_frame("wrap", c, 1'b0, 2'd0);
    end
    @(posedge clk);
    #2;
    chk("wrap_direct", 32'(retire_count), 32'd0);

    // Reset in the middle of a frame.
    step("mid_F", S_F, 1'b0, pk(3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
    step("mid_D", S_D, 1'b0, pk(3'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
    step("mid_E", S_E, 1'b0, pk(3'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
    reset_pulse("rst_midframe");

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain %0d entries left, expected 0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
